// File: rtl/dircc_counter_tick_receiver.sv
// Counter application tick receiver: accepts one inbound tick at a time, read-modify-writes
// the destination device's packed {count, rts} state word and reports the new rts to the scheduler.
module dircc_counter_tick_receiver #(
    parameter int          NUM_DEVICES = 16,
    parameter int          DEV_W       = 4,
    parameter logic [15:0] MAX_TIME    = 16'd100,
    parameter logic [15:0] OUT_FLAG    = 16'h1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DEV_W-1:0] in_dest_dev,
    input  logic [15:0]      in_payload,
    output logic             st_rd_en,
    output logic [DEV_W-1:0] st_rd_addr,
    input  logic [31:0]      st_rd_data,
    output logic             st_wr_en,
    output logic [DEV_W-1:0] st_wr_addr,
    output logic [31:0]      st_wr_data,
    output logic             rts_valid,
    output logic [DEV_W-1:0] rts_dev,
    output logic             rts_set,
    output logic             drop_err,
    output logic [15:0]      last_payload,
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    // One bit wider than the index so an out-of-range limit is always representable.
    localparam logic [DEV_W:0] DEV_LIMIT = (DEV_W+1)'(NUM_DEVICES);

    logic [1:0]       state;
    logic [DEV_W-1:0] dest_q;
    logic             drop_q;
    logic             dest_bad;
    logic [15:0]      cur_count;
    logic [15:0]      next_count;
    logic [15:0]      next_rts;
    logic             unused_rts_bits;

    assign dbg_state = state;
    assign dest_bad  = ({1'b0, in_dest_dev} >= DEV_LIMIT);

    // The stored rts is always rederived from the count, so its old value is never read.
    assign unused_rts_bits = ^st_rd_data[15:0];

    always_comb begin
        cur_count  = st_rd_data[31:16];
        next_count = (cur_count < MAX_TIME) ? cur_count + 16'd1 : cur_count;
        next_rts   = (next_count < MAX_TIME) ? OUT_FLAG : 16'h0;
    end

    // Handshake: a message transfers on a rising edge where in_valid && in_ready; the sender
    // holds in_valid and its payload stable until then, and in_ready never depends on in_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            in_ready     <= 1'b0;
            dest_q       <= '0;
            drop_q       <= 1'b0;
            st_rd_en     <= 1'b0;
            st_rd_addr   <= '0;
            st_wr_en     <= 1'b0;
            st_wr_addr   <= '0;
            st_wr_data   <= '0;
            rts_valid    <= 1'b0;
            rts_dev      <= '0;
            rts_set      <= 1'b0;
            drop_err     <= 1'b0;
            last_payload <= '0;
        end else begin
            st_rd_en  <= 1'b0;
            st_wr_en  <= 1'b0;
            rts_valid <= 1'b0;
            drop_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_ready && in_valid) begin
                        in_ready     <= 1'b0;
                        dest_q       <= in_dest_dev;
                        last_payload <= in_payload;
                        drop_q       <= dest_bad;
                        state        <= S_READ;
                        if (dest_bad) begin
                            drop_err <= 1'b1;
                        end else begin
                            st_rd_en   <= 1'b1;
                            st_rd_addr <= in_dest_dev;
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                S_READ: begin
                    if (drop_q) begin
                        state    <= S_IDLE;
                        in_ready <= 1'b1;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    st_wr_en   <= 1'b1;
                    st_wr_addr <= dest_q;
                    st_wr_data <= {next_count, next_rts};
                    rts_valid  <= 1'b1;
                    rts_dev    <= dest_q;
                    rts_set    <= (next_rts != 16'h0);
                    state      <= S_WRITE;
                end
                S_WRITE: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b1;
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dircc_counter_tick_receiver.sv
// Bench for dircc_counter_tick_receiver: state RAM model, accept-time scoreboard of expected
// reads, writes and drops (with cycle stamps), directed boundary cases and random ticks.
module tb_dircc_counter_tick_receiver;

    localparam int NUM_DEV = 16;
    localparam int DW      = 5;   // wide enough to present index 16 as an out-of-range device
    localparam int EXP_W   = 70;  // {cycle16, dev5, data32, rts_set1, payload16}

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_dest_dev;
    logic [15:0]   in_payload;
    logic          st_rd_en;
    logic [DW-1:0] st_rd_addr;
    logic [31:0]   st_rd_data;
    logic          st_wr_en;
    logic [DW-1:0] st_wr_addr;
    logic [31:0]   st_wr_data;
    logic          rts_valid;
    logic [DW-1:0] rts_dev;
    logic          rts_set;
    logic          drop_err;
    logic [15:0]   last_payload;
    logic [1:0]    dbg_state;

    dircc_counter_tick_receiver #(
        .NUM_DEVICES(NUM_DEV), .DEV_W(DW), .MAX_TIME(16'd100), .OUT_FLAG(16'h1)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_dest_dev(in_dest_dev), .in_payload(in_payload),
        .st_rd_en(st_rd_en), .st_rd_addr(st_rd_addr), .st_rd_data(st_rd_data),
        .st_wr_en(st_wr_en), .st_wr_addr(st_wr_addr), .st_wr_data(st_wr_data),
        .rts_valid(rts_valid), .rts_dev(rts_dev), .rts_set(rts_set),
        .drop_err(drop_err), .last_payload(last_payload), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / cycle count
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- state RAM with a backdoor load port
    logic [31:0]   ram [0:31];
    logic [31:0]   model_mem [0:31];
    logic          bd_en = 1'b0;
    logic [DW-1:0] bd_addr = '0;
    logic [31:0]   bd_data = '0;

    always @(posedge clk) begin
        if (st_rd_en) st_rd_data <= ram[st_rd_addr];
        if (st_wr_en) ram[st_wr_addr] <= st_wr_data;
        if (bd_en) ram[bd_addr] <= bd_data;
    end

    // ---------------- scoreboard
    int n_cmp = 0;
    int n_err = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [20:0]      rd_q[$];
    logic [15:0]      drop_q[$];
    int               acc_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] w);
        logic [15:0] c;
        logic [15:0] n;
        c = w[31:16];
        n = (c < 16'd100) ? c + 16'd1 : c;
        return {n, (n < 16'd100) ? 16'h1 : 16'h0};
    endfunction

    logic [EXP_W-1:0] m_e;
    logic [20:0]      m_r;
    logic [15:0]      m_d;
    logic [31:0]      m_w;

    always @(negedge clk) begin
        if (!reset && in_valid && in_ready) begin
            acc_q.push_back(cyc);
            if (int'(in_dest_dev) >= NUM_DEV) begin
                drop_q.push_back(16'(cyc + 1));
            end else begin
                rd_q.push_back({16'(cyc + 1), in_dest_dev});
                m_w = model_next(model_mem[in_dest_dev]);
                model_mem[in_dest_dev] = m_w;
                exp_q.push_back({16'(cyc + 3), in_dest_dev, m_w, (m_w[15:0] != 16'h0), in_payload});
            end
        end
        if (st_rd_en) begin
            if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
            else begin
                m_r = rd_q.pop_front();
                check("rd_cycle", 64'(cyc), 64'(m_r[20:5]));
                check("rd_addr", 64'(st_rd_addr), 64'(m_r[4:0]));
            end
        end
        if (st_wr_en) begin
            if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
            else begin
                m_e = exp_q.pop_front();
                check("wr_cycle", 64'(cyc), 64'(m_e[69:54]));
                check("wr_addr", 64'(st_wr_addr), 64'(m_e[53:49]));
                check("wr_data", 64'(st_wr_data), 64'(m_e[48:17]));
                check("rts_valid", 64'(rts_valid), 1);
                check("rts_dev", 64'(rts_dev), 64'(m_e[53:49]));
                check("rts_set", 64'(rts_set), 64'(m_e[16]));
                check("last_payload", 64'(last_payload), 64'(m_e[15:0]));
            end
        end else if (rts_valid) begin
            check("rts_unexpected", 1, 0);
        end
        if (drop_err) begin
            if (drop_q.size() == 0) check("drop_unexpected", 1, 0);
            else begin
                m_d = drop_q.pop_front();
                check("drop_cycle", 64'(cyc), 64'(m_d));
            end
        end
    end

    // ---------------- driver tasks
    task automatic set_ram(input int a, input logic [31:0] d);
        bd_en = 1'b1;
        bd_addr = DW'(a);
        bd_data = d;
        model_mem[a] = d;
        @(posedge clk); #1;
        bd_en = 1'b0;
    endtask

    task automatic send(input int dest, input logic [15:0] pay, input bit keep);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_dest_dev = DW'(dest);
        in_payload = pay;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 50; n++) begin
            if (exp_q.size() == 0 && rd_q.size() == 0 && drop_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain_timeout", 64'(exp_q.size() + rd_q.size() + drop_q.size()), 0);
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus
    int a0;
    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_dest_dev = '0;
        in_payload = '0;
        for (int i = 0; i < 32; i++) begin
            ram[i] = '0;
            model_mem[i] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 0);
        check("rst_strobes", 64'({st_rd_en, st_wr_en, rts_valid, drop_err, rts_set}), 0);
        check("rst_state", 64'(dbg_state), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 32; i++)
            set_ram(i, {16'($urandom_range(0, 110)), 16'h1});

        // first tick to a zeroed device, with in_ready timing
        set_ram(3, 32'h0);
        send(3, 16'h1111, 1'b0);
        @(negedge clk); check("busy_t1", 64'(in_ready), 0);
        @(negedge clk); check("busy_t2", 64'(in_ready), 0);
        @(negedge clk); check("busy_t3", 64'(in_ready), 0);
        @(negedge clk); check("ready_t4", 64'(in_ready), 1);
        drain();
        check("ram3", 64'(ram[3]), 64'h0001_0001);

        // count reaches MAX_TIME: rts clears
        set_ram(5, {16'd99, 16'h1});
        send(5, 16'h2222, 1'b0);
        drain();
        check("ram5_max", 64'(ram[5]), 64'({16'd100, 16'h0}));

        // saturation at MAX_TIME, and a corrupt count above it
        send(5, 16'h3333, 1'b0);
        drain();
        check("ram5_sat", 64'(ram[5]), 64'({16'd100, 16'h0}));
        set_ram(9, {16'd200, 16'h1});
        send(9, 16'h4444, 1'b0);
        drain();
        check("ram9_corrupt", 64'(ram[9]), 64'({16'd200, 16'h0}));

        // out-of-range destination is dropped
        send(16, 16'h5555, 1'b0);
        @(negedge clk); check("drop_busy_t1", 64'(in_ready), 0);
        @(negedge clk); check("drop_ready_t2", 64'(in_ready), 1);
        drain();
        check("drop_payload", 64'(last_payload), 64'h5555);

        // back-to-back with in_valid held continuously
        a0 = acc_q.size();
        send(1, 16'h0101, 1'b1);
        send(2, 16'h0202, 1'b0);
        drain();
        check("b2b_accepts", 64'(acc_q.size() - a0), 2);
        check("b2b_gap", 64'(acc_q[a0 + 1] - acc_q[a0]), 4);

        // reset mid-message: write abandoned
        set_ram(7, {16'd10, 16'h1});
        send(7, 16'h7777, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        model_mem[7] = {16'd10, 16'h1};
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_ctrl", 64'({in_ready, st_rd_en, st_wr_en, rts_valid, rts_set, drop_err, dbg_state}), 0);
        check("midrst_data", 64'({st_wr_data, last_payload}), 0);
        check("midrst_addr", 64'({st_rd_addr, st_wr_addr, rts_dev}), 0);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_ready", 64'(in_ready), 1);
        repeat (3) @(negedge clk);
        check("ram7_untouched", 64'(ram[7]), 64'({16'd10, 16'h1}));
        @(posedge clk); #1;

        // random ticks including out-of-range indices and idle gaps
        for (int i = 0; i < 16; i++) begin
            send($urandom_range(0, 17), 16'($urandom_range(0, 65535)), 1'b0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
